// File: rtl/memcopy.sv
// memcopy: byte-serial memory-to-memory copy engine.
//
// Copies `length` bytes from src_addr to dst_addr one byte at a time,
// in ascending order. Each byte is read (READ), the returned data is captured
// one cycle later (LATCH), and then it is written (WRITE). Addresses wrap
// modulo 2^ADDR_W. Overlapping regions are not special-cased.
//
// Optional feature macro: MEMCOPY_FILL_EN
//   When defined, adds fill_mode/fill_byte. A fill transfer writes fill_byte
//   to dst..dst+length-1 at one byte per cycle and never reads memory.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             transfer request, only honoured in IDLE
//   src_addr/dst_addr first source/destination byte address (sampled with start)
//   length            byte count (sampled with start), 0 is legal
//   fill_mode/fill_byte  (MEMCOPY_FILL_EN only) fill request and fill value
//   busy              high whenever not IDLE
//   done              one-cycle completion pulse
//   mem_addr/mem_wdata/mem_write_en/mem_read_en  memory controller request
//   mem_rdata         read data, valid the cycle after mem_read_en is sampled
//
// State | meaning
// IDLE  | waiting for start
// READ  | read strobe out, address = src + i
// LATCH | no strobe, capture returned byte into mem_wdata
// WRITE | write strobe out, address = dst + i, then advance i
// DONE  | done pulse, back to IDLE

module memcopy #(
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W-1:0] length,
`ifdef MEMCOPY_FILL_EN
    input  logic              fill_mode,
    input  logic [7:0]        fill_byte,
`endif
    input  logic [7:0]        mem_rdata,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_write_en,
    output logic              mem_read_en
);

    typedef enum logic [2:0] {IDLE, READ, LATCH, WRITE, DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d, len_q, len_d, i_q, i_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic              busy_q, busy_d, done_q, done_d;
    logic              rd_q, rd_d, wr_q, wr_d;
    logic [ADDR_W-1:0] i_next;

    logic              fill_start;
    logic [7:0]        fill_value;
    logic              fill_q;
`ifdef MEMCOPY_FILL_EN
    logic              fill_d;
    assign fill_start = fill_mode;
    assign fill_value = fill_byte;
`else
    assign fill_start = 1'b0;
    assign fill_value = 8'h00;
    assign fill_q     = 1'b0;
`endif

    // i never exceeds length-1, so i+1 cannot overflow ADDR_W bits.
    assign i_next = i_q + ADDR_W'(1);

    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        dst_d       = dst_q;
        len_d       = len_q;
        i_d         = i_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rd_d        = 1'b0;
        wr_d        = 1'b0;
`ifdef MEMCOPY_FILL_EN
        fill_d      = fill_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    src_d = src_addr;
                    dst_d = dst_addr;
                    len_d = length;
                    i_d   = '0;
`ifdef MEMCOPY_FILL_EN
                    fill_d = fill_start;
`endif
                    if (length == '0) begin
                        state_d = DONE;
                    end else if (fill_start) begin
                        // Fill data is parked in mem_wdata for the whole transfer.
                        state_d     = WRITE;
                        wr_d        = 1'b1;
                        mem_addr_d  = dst_addr;
                        mem_wdata_d = fill_value;
                    end else begin
                        state_d    = READ;
                        rd_d       = 1'b1;
                        mem_addr_d = src_addr;
                    end
                end
            end
            READ: begin
                state_d = LATCH;
            end
            LATCH: begin
                state_d     = WRITE;
                wr_d        = 1'b1;
                mem_wdata_d = mem_rdata;
                mem_addr_d  = dst_q + i_q;
            end
            WRITE: begin
                i_d = i_next;
                if (i_next < len_q) begin
                    if (fill_q) begin
                        state_d    = WRITE;
                        wr_d       = 1'b1;
                        mem_addr_d = dst_q + i_next;
                    end else begin
                        state_d    = READ;
                        rd_d       = 1'b1;
                        mem_addr_d = src_q + i_next;
                    end
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Outputs are registered, so they are derived from the next state.
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            src_q       <= '0;
            dst_q       <= '0;
            len_q       <= '0;
            i_q         <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
`ifdef MEMCOPY_FILL_EN
            fill_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            len_q       <= len_d;
            i_q         <= i_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
`ifdef MEMCOPY_FILL_EN
            fill_q      <= fill_d;
`endif
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign mem_read_en  = rd_q;
    assign mem_write_en = wr_q;

endmodule

// File: doc/memcopy.md
MEMCOPY -- requirements
Module: memcopy

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 17, giving the memory address width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request a transfer, sampled only in IDLE.
REQ-005 The block SHALL have port src_addr, input, ADDR_W bits: first source byte address, sampled with start.
REQ-006 The block SHALL have port dst_addr, input, ADDR_W bits: first destination byte address, sampled with start.
REQ-007 The block SHALL have port length, input, ADDR_W bits: byte count, sampled with start; 0 is legal.
REQ-008 The block SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-010 The block SHALL have port mem_addr, output, ADDR_W bits: address to the memory controller.
REQ-011 The block SHALL have port mem_wdata, output, 8 bits: write data to the memory controller.
REQ-012 The block SHALL have port mem_write_en, output, 1 bit: write strobe.
REQ-013 The block SHALL have port mem_read_en, output, 1 bit: read strobe.
REQ-014 The block SHALL have port mem_rdata, input, 8 bits: read data, valid in the cycle after mem_read_en is sampled high.

Function
REQ-015 All outputs SHALL be registered.
REQ-016 States SHALL be IDLE, READ, LATCH, WRITE and DONE.
REQ-017 In IDLE with start=1 and length!=0, the block SHALL latch the src, dst and length inputs, clear the byte index i, and go to READ.
REQ-018 In IDLE with start=1 and length=0, the block SHALL go straight to DONE with no memory access.
REQ-019 In READ, the block SHALL drive mem_read_en=1 and mem_addr=src+i, then go to LATCH.
REQ-020 In LATCH, the block SHALL drive both strobes 0 and capture mem_rdata into mem_wdata, then go to WRITE.
REQ-021 In WRITE, the block SHALL drive mem_write_en=1, mem_addr=dst+i and the held mem_wdata, then increment i.
REQ-022 From WRITE, the block SHALL go to READ if i+1<length, else to DONE.
REQ-023 In DONE, the block SHALL assert done=1 for exactly one cycle, then go to IDLE.
REQ-024 Each byte SHALL take exactly 3 cycles; for N>0 bytes, done SHALL be high in cycle 3N+1 after the start-sampling edge; for N=0, in cycle 1.
REQ-025 mem_read_en and mem_write_en SHALL never be high in the same cycle.
REQ-026 Both strobes SHALL be 0 in IDLE, LATCH and DONE.
REQ-027 src+i and dst+i SHALL wrap modulo 2^ADDR_W; length up to 2^ADDR_W-1 is legal.
REQ-028 Copy order SHALL be strictly ascending, one byte read then written before the next read.
REQ-029 Overlapping regions SHALL not be special-cased: with dst=src+1, byte src[0] is replicated.
REQ-030 start SHALL be ignored while busy=1; the in-flight transfer is not disturbed.
REQ-031 src_addr, dst_addr and length changing after the start sample SHALL have no effect.
REQ-032 mem_addr SHALL hold its last value in non-access states; mem_wdata SHALL hold until the next LATCH.

Reset
REQ-033 With rst=1 at a rising edge, state SHALL become IDLE.
REQ-034 Reset SHALL set busy=0, done=0, mem_read_en=0, mem_write_en=0, mem_addr=0, mem_wdata=0 and i=0.
REQ-035 Reset SHALL take priority over start and over any in-flight state.
REQ-036 Reset mid-transfer SHALL abort with no further strobes and no done pulse; bytes already written stay written.

Configuration
REQ-037 The macro MEMCOPY_FILL_EN SHALL control an optional fill mode.
REQ-038 When MEMCOPY_FILL_EN is defined, the block SHALL add inputs fill_mode (1 bit) and fill_byte (8 bits), both sampled with start.
REQ-039 When fill_mode=1 at start, the block SHALL skip READ and LATCH and use WRITE only, writing fill_byte to dst+i.
REQ-040 In fill mode, each byte SHALL take 1 cycle; done SHALL be high in cycle N+1 after the start-sampling edge, and src_addr SHALL be ignored.
REQ-041 When MEMCOPY_FILL_EN is undefined, the fill_mode and fill_byte ports SHALL be absent and the block SHALL be copy-only.

Verification
REQ-042 Copy: memory model with 1-cycle read latency, src=0x0100 holding 0x11,0x22,0x33, dst=0x0200, length=3 -> 0x0200..0x0202 = 0x11,0x22,0x33; done in cycle 10; strobes never overlap.
REQ-043 Zero length: length=0 -> done in cycle 1; no strobe ever asserted; busy high for 1 cycle.
REQ-044 Wrap: src=0x1FFFF, dst=0x00010, length=2 -> reads 0x1FFFF then 0x00000; writes 0x00010 then 0x00011.
REQ-045 Busy and reset: start pulses during a length=4 copy are ignored; rst raised in cycle 5 -> strobes 0 next cycle, no done pulse, only byte 0 written.
REQ-046 Fill (MEMCOPY_FILL_EN defined): fill_mode=1, fill_byte=0xA5, dst=0x0300, length=4 -> 0x0300..0x0303 = 0xA5; mem_read_en never high; done in cycle 5.
